// File: rtl/bram_reader.sv
// Purpose : walks COUNT consecutive BRAM addresses from START_ADDR and streams the words out.
// Latency : first word is VALID two edges after the edge that accepts START; one word/clk with READY high.
// Backpr. : READY low stalls issue once the 2-entry buffer plus in-flight read reach 2; DATA_OUT is held.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   START, START_ADDR,  command strobe, first address and word count (0..2^ADDRESS_BITS),
//   COUNT               all sampled in IDLE only
//   LOOP                (only with BRAM_READER_LOOP_EN) repeat the block until STOP/RST
//   STOP                abort: flush buffer and in-flight read, back to IDLE without DONE
//   BUSY, DONE          command active / one-cycle completion pulse
//   RD_ADDRESS, RD_DATA BRAM read port (registered address, data valid one edge later)
//   DATA_OUT, VALID,    output stream taken from the buffer head
//   READY
//
// Optional feature macro: BRAM_READER_LOOP_EN
module bram_reader #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [ADDRESS_BITS-1:0] START_ADDR,
  input  logic [ADDRESS_BITS:0]   COUNT,
`ifdef BRAM_READER_LOOP_EN
  input  logic                    LOOP,
`endif
  input  logic                    STOP,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [ADDRESS_BITS-1:0] RD_ADDRESS,
  input  logic [BITS-1:0]         RD_DATA,
  output logic [BITS-1:0]         DATA_OUT,
  output logic                    VALID,
  input  logic                    READY
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_BITS:0]   REM_ONE  = 1;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRESS_BITS:0]   remain_q, remain_d;
  logic                    inflight_q, inflight_d;
  logic                    done_q, done_d;
  logic [BITS-1:0]         head_q, head_d;
  logic [BITS-1:0]         tail_q, tail_d;
  logic [1:0]              cnt_q, cnt_d;
`ifdef BRAM_READER_LOOP_EN
  logic [ADDRESS_BITS-1:0] start_addr_q, start_addr_d;
  logic [ADDRESS_BITS:0]   count_q, count_d;
  logic                    loop_q, loop_d;
`endif

  logic       pop;
  logic [1:0] occ;    // buffer occupancy after this cycle's pop
  logic [2:0] used;   // occupancy after pop plus the read about to land
  logic       issue;

  always_comb begin
    pop   = (cnt_q != 2'd0) && READY;
    occ   = cnt_q - {1'b0, pop};
    used  = {1'b0, occ} + {2'b0, inflight_q};
    issue = (state_q == S_RUN) && (used < 3'd2);

    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    remain_d   = remain_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
`ifdef BRAM_READER_LOOP_EN
    start_addr_d = start_addr_q;
    count_d      = count_q;
    loop_d       = loop_q;
`endif

    // Two-entry buffer kept as head/tail registers so the head is always DATA_OUT.
    if (pop && (cnt_q == 2'd2)) begin
      head_d = tail_q;
    end
    if (inflight_q) begin
      if (occ == 2'd0) begin
        head_d = RD_DATA;
      end else begin
        tail_d = RD_DATA;
      end
    end
    cnt_d = occ + {1'b0, inflight_q};

    case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          if (COUNT != '0) begin
            state_d   = S_RUN;
            rd_addr_d = START_ADDR;
            remain_d  = COUNT;
`ifdef BRAM_READER_LOOP_EN
            start_addr_d = START_ADDR;
            count_d      = COUNT;
            loop_d       = LOOP;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // The BRAM samples RD_ADDRESS at the end of this cycle; its word lands
        // in the buffer one edge after that.
        if (issue) begin
          inflight_d = 1'b1;
          rd_addr_d  = rd_addr_q + ADDR_ONE;
          remain_d   = remain_q - REM_ONE;
          if (remain_q == REM_ONE) begin
`ifdef BRAM_READER_LOOP_EN
            if (loop_q) begin
              rd_addr_d = start_addr_q;
              remain_d  = count_q;
            end else begin
              state_d = S_DRAIN;
            end
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (occ == 2'd0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except reset: drop buffered and in-flight data.
    if (STOP && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      rd_addr_d  = rd_addr_q;
      inflight_d = 1'b0;
      cnt_d      = 2'd0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
`ifdef BRAM_READER_LOOP_EN
      start_addr_q <= '0;
      count_q      <= '0;
      loop_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
`ifdef BRAM_READER_LOOP_EN
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      loop_q       <= loop_d;
`endif
    end
  end

  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;
  assign RD_ADDRESS = rd_addr_q;
  assign DATA_OUT   = head_q;
  assign VALID      = (cnt_q != 2'd0);

endmodule

// File: tb/tb_bram_reader.sv
// Bench for bram_reader: behavioural BRAM with registered read, a scoreboard queue of
// expected words, a table of block commands and hand-written latency/abort sequences.
module tb_bram_reader;

  logic        CLK = 1'b0;
  logic        RST, START, STOP, READY;
  logic [7:0]  START_ADDR;
  logic [8:0]  COUNT;
  logic [15:0] RD_DATA;
  logic        BUSY, DONE, VALID;
  logic [7:0]  RD_ADDRESS;
  logic [15:0] DATA_OUT;
`ifdef BRAM_READER_LOOP_EN
  logic        LOOP;
`endif

  always #5 CLK = ~CLK;

  bram_reader #(.BITS(16), .ADDRESS_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .COUNT(COUNT),
`ifdef BRAM_READER_LOOP_EN
    .LOOP(LOOP),
`endif
    .STOP(STOP), .BUSY(BUSY), .DONE(DONE), .RD_ADDRESS(RD_ADDRESS), .RD_DATA(RD_DATA),
    .DATA_OUT(DATA_OUT), .VALID(VALID), .READY(READY)
  );

  // Behavioural BRAM read port.
  logic [15:0] mem [0:255];
  always @(posedge CLK) RD_DATA <= mem[RD_ADDRESS];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard state shared between driver and monitor.
  logic [15:0] exp_q [$];
  logic [7:0]  cur_start = 8'h00;
  int          accepted  = 0;
  int          done_seen = 0;
  int          max_ahead = 0;
  bit          got_first = 0;
  logic [15:0] first_word, last_word;

  // Monitor: looks at the DUT on the falling edge, predicting the transfer at the next rising edge.
  initial begin
    logic [7:0]  off;
    int          ahead;
    bit          prev_stall = 0, prev_flush = 0, prev_done = 0;
    logic [15:0] prev_dat = '0;
    logic [15:0] e;
    forever begin
      @(negedge CLK);
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", VALID, 1);
        chk("hold_data", DATA_OUT, prev_dat);
      end
      if (DONE === 1'b1) begin
        done_seen++;
        chk("done_width", prev_done, 0);
        chk("busy_at_done", BUSY, 0);
      end
      if (BUSY === 1'b1) begin
        off   = RD_ADDRESS - cur_start;
        ahead = int'(off) - accepted;
        if (ahead > max_ahead) max_ahead = ahead;
      end
      if ((VALID === 1'b1) && READY && !STOP && !RST) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word", DATA_OUT, e);
        end
        if (!got_first) first_word = DATA_OUT;
        got_first = 1;
        last_word = DATA_OUT;
        accepted++;
      end
      prev_stall = (VALID === 1'b1) && !READY;
      prev_flush = STOP || RST;
      prev_dat   = DATA_OUT;
      prev_done  = (DONE === 1'b1);
    end
  end

  // Issue a command right after a rising edge; returns just after the edge that samples it.
  task automatic start_cmd(input logic [7:0] a, input logic [8:0] c);
    logic [7:0] ad;
    for (int i = 0; i < int'(c); i++) begin
      ad = a + 8'(i);
      exp_q.push_back(mem[ad]);
    end
    cur_start = a; accepted = 0; got_first = 0; done_seen = 0; max_ahead = 0;
    START = 1'b1; START_ADDR = a; COUNT = c;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input logic [7:0] pat, input int limit, output bit ok);
    ok = 0;
    for (int cyc = 1; cyc < limit; cyc++) begin
      READY = pat[3'(cyc)];
      @(posedge CLK); #1;
      if (done_seen != 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [8:0]  cnt;
    logic [7:0]  rdy_pat;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int gaps;

    vecs[0] = '{8'h10, 9'd4,   8'hFF, 16'h00A0, 16'h00A3};
    vecs[1] = '{8'h10, 9'd4,   8'hE9, 16'h00A0, 16'h00A3};  // READY 1,0,0,1,0,1,1,...
    vecs[2] = '{8'hFE, 9'd4,   8'hFF, 16'h018E, 16'h0091};  // address wrap
    vecs[3] = '{8'h00, 9'd256, 8'hA5, 16'h0090, 16'h018F};  // full memory
    vecs[4] = '{8'h30, 9'd1,   8'h55, 16'h00C0, 16'h00C0};
    vecs[5] = '{8'h80, 9'd7,   8'h33, 16'h0110, 16'h0116};

    for (int i = 0; i < 256; i++) mem[i] = 16'(i) + 16'h0090;

    RST = 1'b1; START = 1'b0; STOP = 1'b0; READY = 1'b0;
    START_ADDR = '0; COUNT = '0;
`ifdef BRAM_READER_LOOP_EN
    LOOP = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_addr", RD_ADDRESS, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Latency and throughput: START sampled at E0, VALID after E2, DONE after E6.
    READY = 1'b1;
    start_cmd(8'h10, 9'd4);
    chk("lat_e0_busy", BUSY, 1);
    chk("lat_e0_valid", VALID, 0);
    chk("lat_e0_addr", RD_ADDRESS, 8'h10);
    @(posedge CLK); #1;
    chk("lat_e1_valid", VALID, 0);
    @(posedge CLK); #1;
    chk("lat_e2_valid", VALID, 1);
    chk("lat_e2_data", DATA_OUT, 16'h00A0);
    repeat (3) @(posedge CLK);
    #1;
    chk("lat_e5_done", DONE, 0);
    @(posedge CLK); #1;
    chk("lat_e6_done", DONE, 1);
    chk("lat_e6_busy", BUSY, 0);
    chk("lat_e6_accepted", accepted, 4);
    @(posedge CLK); #1;
    chk("lat_e7_done", DONE, 0);
    chk("lat_sb_empty", exp_q.size(), 0);

    // Command table.
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      READY = vecs[i].rdy_pat[0];
      start_cmd(vecs[i].addr, vecs[i].cnt);
      wait_done(vecs[i].rdy_pat, 2000, ok);
      chk($sformatf("v%0d_done_reached", i), ok, 1);
      READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk($sformatf("v%0d_done_count", i), done_seen, 1);
      chk($sformatf("v%0d_accepted", i), accepted, int'(vecs[i].cnt));
      chk($sformatf("v%0d_first", i), first_word, vecs[i].exp_first);
      chk($sformatf("v%0d_last", i), last_word, vecs[i].exp_last);
      chk($sformatf("v%0d_ahead_le2", i), max_ahead <= 2, 1);
      chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
      chk($sformatf("v%0d_busy_end", i), BUSY, 0);
    end

    // COUNT = 0: DONE pulse, BUSY never high.
    start_cmd(8'h50, 9'd0);
    chk("zero_done", DONE, 1);
    chk("zero_busy", BUSY, 0);
    @(posedge CLK); #1;
    chk("zero_done_clr", DONE, 0);
    chk("zero_busy2", BUSY, 0);

    // STOP with two words buffered, then a new block on the next cycle.
    READY = 1'b0;
    start_cmd(8'h10, 9'd8);
    repeat (5) @(posedge CLK);
    #1;
    chk("stop_pre_valid", VALID, 1);
    STOP = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0;
    exp_q.delete();
    chk("stop_valid", VALID, 0);
    chk("stop_busy", BUSY, 0);
    chk("stop_done", DONE, 0);
    READY = 1'b1;
    start_cmd(8'h40, 9'd3);
    wait_done(8'hFF, 200, ok);
    chk("stop_new_done_reached", ok, 1);
    repeat (3) @(posedge CLK);
    #1;
    chk("stop_new_done_count", done_seen, 1);
    chk("stop_new_accepted", accepted, 3);
    chk("stop_new_first", first_word, 16'h00D0);
    chk("stop_new_sb_empty", exp_q.size(), 0);

    // Reset mid-transfer.
    READY = 1'b0;
    start_cmd(8'h60, 9'd8);
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mrst_busy", BUSY, 0);
    chk("mrst_done", DONE, 0);
    chk("mrst_valid", VALID, 0);
    chk("mrst_data", DATA_OUT, 0);
    chk("mrst_addr", RD_ADDRESS, 0);
    RST = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge CLK);
    #1;
    chk("mrst_no_done", done_seen, 0);
    chk("mrst_idle", BUSY, 0);

`ifdef BRAM_READER_LOOP_EN
    // Looping block: 0x20,0x21,0x22 repeated with no gap and no DONE until STOP.
    LOOP = 1'b1;
    READY = 1'b1;
    start_cmd(8'h20, 9'd3);
    LOOP = 1'b0;
    for (int k = 3; k < 12; k++) exp_q.push_back(mem[8'h20 + 8'(k % 3)]);
    gaps = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0) break;
      if (got_first && !VALID) gaps++;
    end
    chk("loop_sb_empty", exp_q.size(), 0);
    chk("loop_gaps", gaps, 0);
    chk("loop_busy", BUSY, 1);
    READY = 1'b0;
    STOP = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0;
    chk("loop_stop_busy", BUSY, 0);
    chk("loop_stop_valid", VALID, 0);
    chk("loop_no_done", done_seen, 0);
`endif

    @(posedge CLK); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
